// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer slice.
// Holds the controller state encoding and the default WIDTH / PRESCALE
// values used by the top level, the bus interface and the prescaler.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int unsigned DEF_WIDTH    = 4;
    localparam int unsigned DEF_PRESCALE = 1;

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle of the countdown timer.
//   master : drives load, load_val, start, pause, auto_reload;
//            observes count, tc, busy, done
//   slave  : the timer itself (mirror image of master)
interface countdown_timer_if
    import countdown_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output load, load_val, start, pause, auto_reload,
        input  count, tc, busy, done
    );

    modport slave (
        input  load, load_val, start, pause, auto_reload,
        output count, tc, busy, done
    );

endinterface

// File: rtl/countdown_timer_tick_gen.sv
// Prescaler for the countdown timer.
//   CLOCK_50 : system clock
//   rst      : asynchronous active-low reset (already release-synchronised)
//   clear    : return the phase counter to zero
//   enable   : advance the phase counter this cycle
//   tick     : high on the enabled cycle that completes a PRESCALE period
// The phase counter only moves while enabled, so holding enable low freezes
// the phase and the next tick lands exactly where it would have.
module tick_gen
    import countdown_pkg::*;
#(
    parameter int unsigned PRESCALE = DEF_PRESCALE
) (
    input  logic CLOCK_50,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned    CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] phase;

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            phase <= '0;
        end else if (clear) begin
            phase <= '0;
        end else if (enable) begin
            phase <= (phase == LAST) ? '0 : phase + 1'b1;
        end
    end

    assign tick = enable && !clear && (phase == LAST);

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaler, pause and optional auto-reload.
//   CLOCK_50 : system clock, all state on the rising edge
//   rst      : asynchronous active-low reset; assertion is immediate,
//              release passes through a two-flop synchroniser
//   bus      : countdown_timer_if slave
//              in : load, load_val, start, pause, auto_reload
//              out: count, tc, busy, done (all straight from flops)
// Input priority within one cycle is load > start > pause.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned PRESCALE = DEF_PRESCALE
) (
    input  logic             CLOCK_50,
    input  logic             rst,
    countdown_timer_if.slave bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [1:0]       rst_sync;
    logic             rst_int;
    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;
    logic             tc_q;
    logic             busy_q;
    logic             done_q;
    logic             start_go;
    logic             tick_en;
    logic             tick;
    logic             reload_ok;

    // Asynchronous assertion, synchronous release.
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int = rst_sync[1];

    // start is only acted on from IDLE or DONE, and never alongside load.
    assign start_go  = bus.start && !bus.load &&
                       ((state_q == IDLE) || (state_q == DONE));
    // pause freezes the prescaler in the same cycle it is first seen in RUN.
    assign tick_en   = (state_q == RUN) && !bus.load && !bus.pause;
    assign reload_ok = bus.auto_reload && (reload_q != '0);

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst_int),
        .clear    (bus.load || start_go),
        .enable   (tick_en),
        .tick     (tick)
    );

    always_ff @(posedge CLOCK_50 or negedge rst_int) begin
        if (!rst_int) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (bus.load) begin
                count_q  <= bus.load_val;
                reload_q <= bus.load_val;
                state_q  <= IDLE;
                busy_q   <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            if (count_q != '0) begin
                                state_q <= RUN;
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                                tc_q    <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        if (bus.start) begin
                            count_q <= reload_q;
                            if (reload_q != '0) begin
                                state_q <= RUN;
                                busy_q  <= 1'b1;
                                done_q  <= 1'b0;
                            end
                        end
                    end
                    RUN: begin
                        if (bus.pause) begin
                            state_q <= PAUSED;
                        end else if (tick) begin
                            if (count_q == ONE) begin
                                // Reaching zero: tc coincides with count==0.
                                count_q <= '0;
                                tc_q    <= 1'b1;
                                if (!reload_ok) begin
                                    state_q <= DONE;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end
                            end else if (count_q == '0) begin
                                // Sitting at zero under auto-reload: the next
                                // tick restores the reload value.
                                if (reload_ok) begin
                                    count_q <= reload_q;
                                end else begin
                                    state_q <= DONE;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end
                            end else begin
                                count_q <= count_q - ONE;
                            end
                        end
                    end
                    PAUSED: begin
                        if (!bus.pause) begin
                            state_q <= RUN;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule
